multithread_fetch_unit: RTL and testbench

MULTITHREAD_FETCH_UNIT -- requirements
Module: multithread_fetch_unit

---
 rtl/multithread_fetch_unit.sv | 120 ++++++++++++
 tb/tb_multithread_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multithread_fetch_unit.sv
// Multithreaded fetch unit: per-thread PC registers with a round-robin issue
// scheduler, branch-target steering and EX-stage redirects.
// Optional feature: define MT_FETCH_PERF_CNT_EN to add o_fetch_count, a
// saturating 32-bit counter of issued fetches.
module multithread_fetch_unit #(
    parameter int                         ADDRESS_WIDTH   = 32,
    parameter int                         NUM_THREADS     = 4,
    parameter int                         THREAD_ID_WIDTH = 2,
    parameter int                         FETCH_BYTES     = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC        = '0,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC_STRIDE = 'h1000
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic                       i_Stall,
    input  logic [NUM_THREADS-1:0]     i_thread_enable,
    input  logic                       i_branch_taken,
    input  logic [ADDRESS_WIDTH-1:0]   i_current_target,
    input  logic                       i_redirect_valid,
    input  logic [THREAD_ID_WIDTH-1:0] i_redirect_thread,
    input  logic [ADDRESS_WIDTH-1:0]   i_redirect_pc,
    output logic [ADDRESS_WIDTH-1:0]   o_PC,
    output logic [THREAD_ID_WIDTH-1:0] o_thread,
    output logic                       o_valid
`ifdef MT_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                o_fetch_count
`endif
);

    logic [ADDRESS_WIDTH-1:0]   pc_q [NUM_THREADS];
    logic [THREAD_ID_WIDTH-1:0] last_thread_q;

    logic [NUM_THREADS-1:0]     redirect_hit;
    logic [NUM_THREADS-1:0]     eligible;
    logic [THREAD_ID_WIDTH-1:0] cand;
    logic [THREAD_ID_WIDTH-1:0] sel_thread;
    logic                       sel_found;
    logic                       issue;

    // Decode the redirect target; thread IDs at or above NUM_THREADS match
    // no slot and are therefore ignored.
    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            redirect_hit[i] = i_redirect_valid &&
                              (i_redirect_thread == THREAD_ID_WIDTH'(i));
            eligible[i]     = i_thread_enable[i] && !redirect_hit[i];
        end
    end

    // Round-robin search starting just after the last issued thread.
    always_comb begin
        // NOTE: every output of this block gets a default before the search
        // loop so no path leaves a value unassigned and no latch is inferred.
        cand       = last_thread_q;
        sel_thread = '0;
        sel_found  = 1'b0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            if (cand == THREAD_ID_WIDTH'(NUM_THREADS - 1))
                cand = '0;
            else
                cand = cand + THREAD_ID_WIDTH'(1);
            if (!sel_found && eligible[cand]) begin
                sel_found  = 1'b1;
                sel_thread = cand;
            end
        end
    end

    assign issue = !i_Stall && sel_found;

    // Issue register, scheduler pointer and per-thread PC file.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // read in this block sees the pre-edge value.
        if (i_Reset) begin
            o_PC          <= '0;
            o_thread      <= '0;
            o_valid       <= 1'b0;
            last_thread_q <= THREAD_ID_WIDTH'(NUM_THREADS - 1);
            // NOTE: the PC file is a handful of flops, not a RAM, and each
            // thread needs a distinct architectural start address, so it is
            // reset explicitly.
            for (int i = 0; i < NUM_THREADS; i++)
                pc_q[i] <= RESET_PC + ADDRESS_WIDTH'(i) * RESET_PC_STRIDE;
        end else begin
            if (!i_Stall) begin
                if (sel_found) begin
                    o_PC          <= pc_q[sel_thread];
                    o_thread      <= sel_thread;
                    o_valid       <= 1'b1;
                    last_thread_q <= sel_thread;
                    pc_q[sel_thread] <= i_branch_taken
                                        ? i_current_target
                                        : pc_q[sel_thread] + ADDRESS_WIDTH'(FETCH_BYTES);
                end else begin
                    o_valid <= 1'b0;
                end
            end
            // Redirect is written last so it wins over any issue update.
            for (int i = 0; i < NUM_THREADS; i++)
                if (redirect_hit[i])
                    pc_q[i] <= i_redirect_pc;
        end
    end

`ifdef MT_FETCH_PERF_CNT_EN
    // Count cycles in which o_valid is loaded with 1, saturating at all-ones.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            o_fetch_count <= '0;
        else if (issue && (o_fetch_count != 32'hFFFF_FFFF))
            o_fetch_count <= o_fetch_count + 32'd1;
    end
`else
    logic unused_issue;
    assign unused_issue = issue;
`endif

endmodule

// File: tb/tb_multithread_fetch_unit.sv
// Self-checking bench for multithread_fetch_unit (default parameters).
// Expected fetches are pushed to a scoreboard queue as each cycle's stimulus
// is applied and popped/compared after the clock edge that produces them.
module tb_multithread_fetch_unit;

    localparam int AW  = 32;
    localparam int NT  = 4;
    localparam int TW  = 2;

    logic          i_Clk;
    logic          i_Reset;
    logic          i_Stall;
    logic [NT-1:0] i_thread_enable;
    logic          i_branch_taken;
    logic [AW-1:0] i_current_target;
    logic          i_redirect_valid;
    logic [TW-1:0] i_redirect_thread;
    logic [AW-1:0] i_redirect_pc;
    logic [AW-1:0] o_PC;
    logic [TW-1:0] o_thread;
    logic          o_valid;
`ifdef MT_FETCH_PERF_CNT_EN
    logic [31:0]   o_fetch_count;
`endif

    multithread_fetch_unit dut (
        .i_Clk             (i_Clk),
        .i_Reset           (i_Reset),
        .i_Stall           (i_Stall),
        .i_thread_enable   (i_thread_enable),
        .i_branch_taken    (i_branch_taken),
        .i_current_target  (i_current_target),
        .i_redirect_valid  (i_redirect_valid),
        .i_redirect_thread (i_redirect_thread),
        .i_redirect_pc     (i_redirect_pc),
        .o_PC              (o_PC),
        .o_thread          (o_thread),
        .o_valid           (o_valid)
`ifdef MT_FETCH_PERF_CNT_EN
        ,
        .o_fetch_count     (o_fetch_count)
`endif
    );

    typedef struct {
        logic          valid;
        logic [AW-1:0] pc;
        logic [TW-1:0] thread;
    } fetch_t;

    fetch_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Watchdog: the run is a fixed number of cycles, so this only fires on a
    // broken simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Push the expected outcome of this cycle, clock once, then pop and compare.
    task automatic step(input string tag, input logic v, input logic [AW-1:0] pc,
                        input logic [TW-1:0] thr);
        fetch_t e;
        fetch_t got;
        e.valid = v; e.pc = pc; e.thread = thr;
        exp_q.push_back(e);
        @(posedge i_Clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            got = exp_q.pop_front();
            check({tag, "_valid"}, 64'(o_valid), 64'(got.valid));
            check({tag, "_pc"},    64'(o_PC),    64'(got.pc));
            check({tag, "_thr"},   64'(o_thread), 64'(got.thread));
        end
    endtask

    // Asynchronous reset pulse applied between edges; outputs must clear
    // before any clock edge arrives.
    task automatic reset_pulse(input string tag);
        i_Reset = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 64'(o_valid),  64'd0);
        check({tag, "_rst_pc"},    64'(o_PC),     64'd0);
        check({tag, "_rst_thr"},   64'(o_thread), 64'd0);
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b0;
    endtask

    initial begin
        i_Reset           = 1'b1;
        i_Stall           = 1'b0;
        i_thread_enable   = 4'hF;
        i_branch_taken    = 1'b0;
        i_current_target  = '0;
        i_redirect_valid  = 1'b0;
        i_redirect_thread = '0;
        i_redirect_pc     = '0;

        // Reset state
        @(posedge i_Clk);
        #1;
        check("init_valid", 64'(o_valid),  64'd0);
        check("init_pc",    64'(o_PC),     64'd0);
        check("init_thr",   64'(o_thread), 64'd0);
        i_Reset = 1'b0;

        // All threads enabled, sequential fetch
        step("rr0", 1'b1, 32'h0000, 2'd0);
        step("rr1", 1'b1, 32'h1000, 2'd1);
        step("rr2", 1'b1, 32'h2000, 2'd2);
        step("rr3", 1'b1, 32'h3000, 2'd3);
        step("rr4", 1'b1, 32'h0004, 2'd0);

        // Mid-stream reset, then only threads 0 and 2 enabled
        reset_pulse("rstA");
        i_thread_enable = 4'b0101;
        step("alt0", 1'b1, 32'h0000, 2'd0);
        step("alt1", 1'b1, 32'h2000, 2'd2);
        step("alt2", 1'b1, 32'h0004, 2'd0);
        step("alt3", 1'b1, 32'h2004, 2'd2);

        // Re-enable all; t1/t3 resume at stored PCs. Branch on t1's issue.
        i_thread_enable = 4'hF;
        step("br0", 1'b1, 32'h3000, 2'd3);
        step("br1", 1'b1, 32'h0008, 2'd0);
        i_branch_taken   = 1'b1;
        i_current_target = 32'h8000;
        step("br2", 1'b1, 32'h1000, 2'd1);
        i_branch_taken   = 1'b0;
        i_current_target = 32'hDEAD_0000;
        step("br3", 1'b1, 32'h2008, 2'd2);
        step("br4", 1'b1, 32'h3004, 2'd3);
        step("br5", 1'b1, 32'h000C, 2'd0);
        step("br6", 1'b1, 32'h8000, 2'd1);

        // Redirect t2 in the cycle it would issue: t3 goes instead
        i_redirect_valid  = 1'b1;
        i_redirect_thread = 2'd2;
        i_redirect_pc     = 32'h40;
        step("rd0", 1'b1, 32'h3008, 2'd3);
        i_redirect_valid  = 1'b0;
        step("rd1", 1'b1, 32'h0010, 2'd0);
        step("rd2", 1'b1, 32'h8004, 2'd1);
        step("rd3", 1'b1, 32'h0040, 2'd2);

        // Stall three cycles with a redirect of t0 in the first one
        i_Stall           = 1'b1;
        i_redirect_valid  = 1'b1;
        i_redirect_thread = 2'd0;
        i_redirect_pc     = 32'h100;
        step("st0", 1'b1, 32'h0040, 2'd2);
        i_redirect_valid  = 1'b0;
        step("st1", 1'b1, 32'h0040, 2'd2);
        step("st2", 1'b1, 32'h0040, 2'd2);
        i_Stall = 1'b0;
        step("st3", 1'b1, 32'h300C, 2'd3);
        step("st4", 1'b1, 32'h0100, 2'd0);

        // No thread enabled: valid drops, PC/thread held
        i_thread_enable = 4'b0000;
        step("dis0", 1'b0, 32'h0100, 2'd0);
        step("dis1", 1'b0, 32'h0100, 2'd0);
        // Only t3 enabled: pointer held at t0, t3 resumes at its stored PC
        i_thread_enable = 4'b1000;
        step("dis2", 1'b1, 32'h3010, 2'd3);
        step("dis3", 1'b1, 32'h3014, 2'd3);

        // Reset mid-stream restarts at thread 0
        i_thread_enable = 4'hF;
        reset_pulse("rstB");
        step("rs0", 1'b1, 32'h0000, 2'd0);
        step("rs1", 1'b1, 32'h1000, 2'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
